// File: rtl/decode_4_16.sv
// Registered 4-to-16 one-hot decoder with selectable output polarity.
// in[0] is the LSB of the index; out[k] is the line for index k.
module decode_4_16 #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [0:3]  in,
  output logic [0:15] out,
  output logic        valid
);

  logic [3:0]  w_index;
  logic [0:15] w_onehot;
  logic [0:15] w_decoded;
  logic [0:15] r_out;
  logic        r_valid;

  // Rebuild the index with in[0] as the least-significant bit.
  assign w_index = {in[3], in[2], in[1], in[0]};

  always_comb begin
    w_onehot          = '0;
    w_onehot[w_index] = 1'b1;
  end

  assign w_decoded = ACTIVE_HIGH ? w_onehot : ~w_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= ACTIVE_HIGH ? 16'h0000 : 16'hFFFF;
      r_valid <= 1'b0;
    end else if (en) begin
      r_out   <= w_decoded;
      r_valid <= 1'b1;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

endmodule

// File: tb/tb_decode_4_16.sv
// Self-checking bench for decode_4_16, covering both output polarities.
module tb_decode_4_16;

  logic        clk;
  logic        rst;
  logic        en;
  logic [0:3]  in;
  logic [0:15] outHigh;
  logic        validHigh;
  logic [0:15] outLow;
  logic        validLow;

  int errorCount;
  int checkCount;

  decode_4_16 #(.ACTIVE_HIGH(1'b1)) dutHigh (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .out   (outHigh),
    .valid (validHigh)
  );

  decode_4_16 #(.ACTIVE_HIGH(1'b0)) dutLow (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .out   (outLow),
    .valid (validLow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive inputs, then sample one time unit after the next rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [0:3] idx);
    rst = r;
    en  = e;
    in  = idx;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] refDecode(input logic [0:3] idx);
    int k;
    k = idx[0] * 1 + idx[1] * 2 + idx[2] * 4 + idx[3] * 8;
    return 16'h8000 >> k;
  endfunction

  logic [3:0]  sweep [16] = '{4'h0, 4'h8, 4'h4, 4'hC, 4'h2, 4'hA, 4'h6, 4'hE,
                               4'h1, 4'h9, 4'h5, 4'hD, 4'h3, 4'hB, 4'h7, 4'hF};
  logic [15:0] modelOut;
  logic        modelValid;
  logic [0:3]  randIn;
  logic        randEn;

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst = 1'b1;
    en  = 1'b1;
    in  = 4'hF;
    @(negedge clk);

    applyStimulus(1'b1, 1'b1, 4'hF);
    applyStimulus(1'b1, 1'b1, 4'hF);
    checkOutput("resetOut", outHigh, 16'h0000);
    checkOutput("resetValid", {15'd0, validHigh}, 16'd0);
    checkOutput("resetOutLow", outLow, 16'hFFFF);
    checkOutput("resetValidLow", {15'd0, validLow}, 16'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, sweep[i]);
      checkOutput($sformatf("sweepOut%0d", i), outHigh, 16'h8000 >> i);
      checkOutput($sformatf("sweepValid%0d", i), {15'd0, validHigh}, 16'd1);
      checkOutput($sformatf("sweepOutLow%0d", i), outLow, ~(16'h8000 >> i));
    end
    checkOutput("lowLastIsFFFE", outLow, 16'hFFFE);

    applyStimulus(1'b0, 1'b1, 4'h0);
    checkOutput("lowFirstIs7FFF", outLow, 16'h7FFF);

    applyStimulus(1'b0, 1'b1, 4'h4);
    checkOutput("holdLoad", outHigh, 16'h2000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'hF);
      checkOutput($sformatf("holdOut%0d", i), outHigh, 16'h2000);
      checkOutput($sformatf("holdValid%0d", i), {15'd0, validHigh}, 16'd1);
    end
    applyStimulus(1'b0, 1'b1, 4'hF);
    checkOutput("holdRelease", outHigh, 16'h0001);

    applyStimulus(1'b1, 1'b1, 4'h8);
    checkOutput("collisionOut", outHigh, 16'h0000);
    checkOutput("collisionValid", {15'd0, validHigh}, 16'd0);
    checkOutput("collisionOutLow", outLow, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 4'h8);
    checkOutput("postResetOut", outHigh, 16'h4000);
    checkOutput("postResetValid", {15'd0, validHigh}, 16'd1);

    modelOut   = 16'h4000;
    modelValid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      randIn = 4'($urandom_range(0, 15));
      randEn = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, randEn, randIn);
      if (randEn) begin
        modelOut   = refDecode(randIn);
        modelValid = 1'b1;
      end
      checkOutput("randOut", outHigh, modelOut);
      checkOutput("randOutLow", outLow, ~modelOut);
      checkOutput("randValid", {15'd0, validHigh}, {15'd0, modelValid});
      if (validHigh)
        checkOutput("randPopcount", 16'($countones(outHigh)), 16'd1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
